// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding, data width and baud divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
  localparam int DATA_BITS = 8;
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: DIV-cycle counter (clk, active-low async reset, sync clr) emitting a one-cycle tick on count DIV-1
module uart_baud_tick #(
  parameter int DIV = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-to-line UART TX; s_valid/s_ready/s_data handshake in, registered tx line plus tx_busy/tx_done pulse out
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate
  uart_tx_state_e state, state_n;
  logic [7:0] sh, sh_n;
  logic [2:0] idx, idx_n;
  logic       stop_idx, stop_n, par, par_n, tx_n, rdy_en, tick, last_stop;
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state == IDLE),
    .tick (tick)
  );
  assign s_ready   = state == IDLE && rdy_en;
  assign tx_busy   = state != IDLE;
  assign last_stop = STOP_BITS == 1 || stop_idx;
  assign tx_done   = state == STOP && tick && last_stop;
  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    stop_n  = stop_idx;
    par_n   = par;
    case (state)
      IDLE:
        if (s_valid && s_ready) begin
          state_n = START;
          sh_n    = s_data;
          par_n   = (^s_data) ^ (PARITY_ODD != 0);
        end
      START: state_n = tick ? DATA : START;
      DATA:
        if (tick) begin
          sh_n    = sh >> 1;
          idx_n   = idx + 3'd1;
          state_n = idx == 3'(DATA_BITS - 1) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
        end
      PARITY: state_n = tick ? STOP : PARITY;
      STOP:
        if (tick) begin
          stop_n  = last_stop ? 1'b0 : ~stop_idx;
          state_n = last_stop ? IDLE : STOP;
        end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      sh       <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
      rdy_en   <= 1'b0;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      idx      <= idx_n;
      stop_idx <= stop_n;
      par      <= par_n;
      tx       <= tx_n;
      rdy_en   <= 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed self-checking bench over default, parity, two-stop and small-divisor builds
module tb_uart_tx_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] sv = '0;
  logic [4:0] rdy, tx, busy, done;
  logic [7:0] sd [5];
  int ncmp = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  uart_tx_serializer u0 (
    .clk(clk), .reset(reset), .s_valid(sv[0]), .s_data(sd[0]),
    .s_ready(rdy[0]), .tx(tx[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_serializer #(.CLK_FREQ(4), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .s_valid(sv[1]), .s_data(sd[1]),
    .s_ready(rdy[1]), .tx(tx[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_serializer #(.CLK_FREQ(4), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .s_valid(sv[2]), .s_data(sd[2]),
    .s_ready(rdy[2]), .tx(tx[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_serializer #(.CLK_FREQ(4), .BAUD(1), .PARITY_EN(1), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .s_valid(sv[3]), .s_data(sd[3]),
    .s_ready(rdy[3]), .tx(tx[3]), .tx_busy(busy[3]), .tx_done(done[3]));
  uart_tx_serializer #(.CLK_FREQ(4), .BAUD(1)) u4 (
    .clk(clk), .reset(reset), .s_valid(sv[4]), .s_data(sd[4]),
    .s_ready(rdy[4]), .tx(tx[4]), .tx_busy(busy[4]), .tx_done(done[4]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic frame(input string tag, input int k, input logic [7:0] d, input int div,
                       input int nb, input logic [11:0] ev, input bit keep);
    int n_tot, txb, dc, dat, bb;
    n_tot = nb * div;
    txb = 0;
    dc = 0;
    dat = 0;
    bb = 0;
    chk({tag, " ready_before"}, 32'(rdy[k]), 1);
    sv[k] = 1'b1;
    sd[k] = d;
    for (int n = 1; n <= n_tot; n++) begin
      @(negedge clk);
      if (n == 1) begin
        sd[k] = ~d;
        if (!keep) sv[k] = 1'b0;
      end
      if (tx[k] !== ev[(n - 1) / div]) txb++;
      if (done[k] === 1'b1) begin
        dc++;
        dat = n;
      end
      if (busy[k] !== 1'b1 || rdy[k] !== 1'b0) bb++;
    end
    chk({tag, " tx_bit_errors"}, txb, 0);
    chk({tag, " done_count"}, dc, 1);
    chk({tag, " done_cycle"}, dat, n_tot);
    chk({tag, " busy_ready_errors"}, bb, 0);
    @(negedge clk);
    chk({tag, " idle_tx"}, 32'(tx[k]), 1);
    chk({tag, " idle_busy"}, 32'(busy[k]), 0);
    chk({tag, " idle_ready"}, 32'(rdy[k]), 1);
    chk({tag, " idle_done"}, 32'(done[k]), 0);
  endtask
  initial begin
    int dc;
    foreach (sd[i]) sd[i] = 8'h00;
    reset = 1'b0;
    sv[0] = 1'b1;
    sd[0] = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst tx", 32'(tx), 32'h1F);
      chk("rst ready", 32'(rdy), 0);
      chk("rst busy", 32'(busy), 0);
    end
    sv[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("release ready", 32'(rdy), 32'h1F);
    chk("release busy", 32'(busy), 0);
    chk("release tx", 32'(tx), 32'h1F);
    frame("a5", 0, 8'hA5, 868, 10, 12'h34A, 1'b0);
    frame("b2b_00", 0, 8'h00, 868, 10, 12'h200, 1'b1);
    frame("b2b_ff", 0, 8'hFF, 868, 10, 12'h3FE, 1'b1);
    frame("b2b_55", 0, 8'h55, 868, 10, 12'h2AA, 1'b0);
    frame("par_even", 1, 8'h07, 4, 11, 12'h60E, 1'b0);
    frame("par_odd", 2, 8'h07, 4, 11, 12'h40E, 1'b0);
    frame("stop2", 3, 8'h07, 4, 12, 12'hE0E, 1'b0);
    sv[0] = 1'b1;
    sd[0] = 8'h3C;
    for (int n = 1; n <= 5 * 868 + 400; n++) begin
      @(negedge clk);
      if (n == 1) sv[0] = 1'b0;
    end
    chk("abort pre tx", 32'(tx[0]), 1);
    chk("abort pre busy", 32'(busy[0]), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort tx", 32'(tx[0]), 1);
    chk("abort busy", 32'(busy[0]), 0);
    chk("abort ready", 32'(rdy[0]), 0);
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) dc++;
    end
    chk("abort no_done", dc, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort release ready", 32'(rdy[0]), 1);
    frame("after_rst_81", 0, 8'h81, 868, 10, 12'h302, 1'b0);
    frame("div4_01", 4, 8'h01, 4, 10, 12'h202, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
